// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg -- subset of the CCI-P interface definitions used by the
// HardCloud read path: cache-line address/data types, the c0 request and
// response header layouts and their encodings.
package ccip_if_pkg;

    localparam int CCIP_CLADDR_WIDTH = 42;
    localparam int CCIP_CLDATA_WIDTH = 512;
    localparam int CCIP_MDATA_WIDTH  = 16;

    typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
    typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;
    typedef logic [CCIP_MDATA_WIDTH-1:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

endpackage

// File: rtl/hc_pkg.sv
// hc_pkg -- definitions shared between the HardCloud AFU (ccip_std_afu)
// and its read engine: read-engine state encoding, CSR offsets and
// control-word values, and a helper that builds a single-line read header.
package hc_pkg;

    import ccip_if_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_hc_rd_state;

    // MMIO CSR byte offsets
    localparam logic [15:0] HC_DSM_BASE_LOW     = 16'h0110;
    localparam logic [15:0] HC_DSM_BASE_HIGH    = 16'h0114;
    localparam logic [15:0] HC_CONTROL          = 16'h0118;
    localparam logic [15:0] HC_BUFFER_ADDRESS_0 = 16'h0120;
    localparam logic [15:0] HC_BUFFER_SIZE_0    = 16'h0128;

    // HC_CONTROL command words
    localparam logic [31:0] HC_CONTROL_ASSERT_RST   = 32'h0000_0000;
    localparam logic [31:0] HC_CONTROL_DEASSERT_RST = 32'h0000_0001;
    localparam logic [31:0] HC_CONTROL_START        = 32'h0000_0003;
    localparam logic [31:0] HC_CONTROL_STOP         = 32'h0000_0007;

    localparam int HC_ADDR_W = $bits(t_ccip_clAddr);

    // Single-line, VA-channel, invalidating read; every other field zero.
    function automatic t_ccip_c0_ReqMemHdr hc_rd_req_hdr(input t_ccip_clAddr addr,
                                                        input t_ccip_mdata  mdata);
        t_ccip_c0_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VA;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_RDLINE_I;
        h.address  = addr;
        h.mdata    = mdata;
        return h;
    endfunction

endpackage

// File: rtl/hc_sync_fifo.sv
// hc_sync_fifo -- single-clock FIFO with occupancy count.
//   clk, reset_n   : clock, asynchronous active-low reset (control state only)
//   push_i/push_data_i : write strobe and data (dropped only when full and not popping)
//   pop_i          : remove head entry (ignored when empty)
//   valid_o/data_o : head entry; data_o is zero whenever the FIFO is empty
//   count_o        : number of stored entries, 0..DEPTH
// Outputs come straight from storage/pointer registers, so there is no
// combinational path from push to the head. Push and pop in one cycle are
// both honoured.
module hc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/hc_read_engine.sv
// hc_read_engine -- multi-line CCI-P c0 read engine for the HardCloud AFU.
//   clk, reset_n         : pClk, asynchronous active-low reset
//   start                : begins a transfer (only sampled in IDLE)
//   base_addr, num_lines : first cache-line address and line count, latched on start
//   busy, done           : transfer in progress / one-cycle completion pulse
//   c0_tx_valid, c0_tx_hdr : registered single-line read requests
//   c0TxAlmFull          : shell back-pressure on the c0 request channel
//   c0_rx_rspValid, c0_rx_hdr, c0_rx_data : read responses (any order)
//   out_valid, out_ready, out_data, out_idx : buffered line stream, out_idx = request mdata
// Reads are credited against the response FIFO: a request is only issued
// when every outstanding read plus everything already buffered still fits.
module hc_read_engine
    import ccip_if_pkg::*;
    import hc_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  t_ccip_clAddr       base_addr,
    input  logic [CNT_W-1:0]   num_lines,
    output logic               busy,
    output logic               done,
    output logic               c0_tx_valid,
    output t_ccip_c0_ReqMemHdr c0_tx_hdr,
    input  logic               c0TxAlmFull,
    input  logic               c0_rx_rspValid,
    input  t_ccip_c0_RspMemHdr c0_rx_hdr,
    input  t_ccip_clData       c0_rx_data,
    output logic               out_valid,
    input  logic               out_ready,
    output t_ccip_clData       out_data,
    output logic [IDX_W-1:0]   out_idx
);

    localparam int CW    = $clog2(FIFO_DEPTH+1);
    localparam int FW    = IDX_W + $bits(t_ccip_clData);
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    t_hc_rd_state       state_q, state_d;
    t_ccip_clAddr       base_q, base_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   received_q, received_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               tx_valid_q;
    t_ccip_c0_ReqMemHdr tx_hdr_q;

    logic [CW-1:0]      fifo_count;
    logic [FW-1:0]      fifo_data;
    logic               fifo_valid;
    logic [CW:0]        credit_used;
    logic               issue, accept, start_ok;
    logic               unused_hdr;

    // Header fields other than resp_type/mdata carry nothing for this engine.
    assign unused_hdr = ^{c0_rx_hdr};

    assign start_ok    = (state_q == IDLE) && start;
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign issue       = (state_q == ISSUE) && !c0TxAlmFull &&
                         (issued_q < num_q) && (credit_used < CREDITS);
    assign accept      = c0_rx_rspValid && (c0_rx_hdr.resp_type == eRSP_RDLINE) &&
                         ((state_q == ISSUE) || (state_q == DRAIN));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_lines == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (issued_q == num_q) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((received_q == num_q) && (fifo_count == '0)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        received_d = received_q;
        inflight_d = inflight_q;
        if (start_ok) begin
            base_d     = base_addr;
            num_d      = num_lines;
            issued_d   = '0;
            received_d = '0;
            inflight_d = '0;
        end else begin
            if (issue)  issued_d   = issued_q + CNT_W'(1);
            if (accept) received_d = received_q + CNT_W'(1);
            case ({issue, accept})
                2'b10:   inflight_d = inflight_q + CW'(1);
                2'b01:   inflight_d = inflight_q - CW'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            inflight_q <= '0;
            tx_valid_q <= 1'b0;
            tx_hdr_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            inflight_q <= inflight_d;
            tx_valid_q <= issue;
            // Address arithmetic wraps naturally at the 42-bit line address width.
            if (issue) begin
                tx_hdr_q <= hc_rd_req_hdr(base_q + t_ccip_clAddr'(issued_q),
                                          t_ccip_mdata'(issued_q[IDX_W-1:0]));
            end
        end
    end

    assign c0_tx_valid = tx_valid_q;
    assign c0_tx_hdr   = tx_hdr_q;

    hc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (accept),
        .push_data_i ({c0_rx_hdr.mdata[IDX_W-1:0], c0_rx_data}),
        .pop_i       (out_valid && out_ready),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .count_o     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_idx   = fifo_data[FW-1 -: IDX_W];
    assign out_data  = fifo_data[$bits(t_ccip_clData)-1:0];

endmodule

// File: tb/tb_hc_read_engine.sv
module tb_hc_read_engine;

    import ccip_if_pkg::*;

    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 32;
    localparam int IDX_W      = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    t_ccip_clAddr       base_addr = '0;
    logic [CNT_W-1:0]   num_lines = '0;
    logic               busy, done;
    logic               c0_tx_valid;
    t_ccip_c0_ReqMemHdr c0_tx_hdr;
    logic               c0TxAlmFull = 1'b0;
    logic               c0_rx_rspValid = 1'b0;
    t_ccip_c0_RspMemHdr c0_rx_hdr = '0;
    t_ccip_clData       c0_rx_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    t_ccip_clData       out_data;
    logic [IDX_W-1:0]   out_idx;

    always #5 clk = ~clk;

    hc_read_engine #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_lines      (num_lines),
        .busy           (busy),
        .done           (done),
        .c0_tx_valid    (c0_tx_valid),
        .c0_tx_hdr      (c0_tx_hdr),
        .c0TxAlmFull    (c0TxAlmFull),
        .c0_rx_rspValid (c0_rx_rspValid),
        .c0_rx_hdr      (c0_rx_hdr),
        .c0_rx_data     (c0_rx_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_idx        (out_idx)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        t_ccip_clData     data;
    } exp_t;

    typedef struct {
        t_ccip_c0_ReqMemHdr hdr;
        int                 cyc;
    } req_t;

    exp_t               exp_q[$];
    t_ccip_c0_ReqMemHdr pend_q[$];
    req_t               req_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_req    = 0;
    int n_rsp    = 0;
    int n_out    = 0;
    int done_cnt = 0;

    bit               popped;
    logic             got_req, got_vld, got_busy, got_done;
    logic [IDX_W-1:0] got_idx;
    t_ccip_clData     got_data;

    function automatic t_ccip_clData line_data(input t_ccip_clAddr a);
        t_ccip_clData d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = a[31:0] ^ (32'h5A00_0000 + 32'(i));
        return d;
    endfunction

    function automatic t_ccip_c0_ReqMemHdr exp_hdr(input t_ccip_clAddr a, input int k);
        t_ccip_c0_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VA;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_RDLINE_I;
        h.address  = a;
        h.mdata    = t_ccip_mdata'(k);
        return h;
    endfunction

    // One clock: sample DUT at the falling edge, then drive this cycle's inputs.
    // rsp_mode: 0 no response, 1 answer oldest pending request, 2 answer newest.
    task automatic tick(input bit rdy, input int rsp_mode);
        t_ccip_c0_ReqMemHdr h;
        @(negedge clk);
        cyc++;
        got_req  = c0_tx_valid;
        got_vld  = out_valid;
        got_idx  = out_idx;
        got_data = out_data;
        got_busy = busy;
        got_done = done;
        if (c0_tx_valid) begin
            pend_q.push_back(c0_tx_hdr);
            req_log.push_back('{c0_tx_hdr, cyc});
            n_req++;
        end
        if (done) done_cnt++;
        popped = out_valid && rdy;
        if (popped) n_out++;
        out_ready      = rdy;
        start          = 1'b0;
        c0_rx_rspValid = 1'b0;
        if (rsp_mode != 0 && pend_q.size() != 0) begin
            if (rsp_mode == 1) h = pend_q.pop_front();
            else               h = pend_q.pop_back();
            c0_rx_hdr           = '0;
            c0_rx_hdr.resp_type = eRSP_RDLINE;
            c0_rx_hdr.mdata     = h.mdata;
            c0_rx_data          = line_data(h.address);
            c0_rx_rspValid      = 1'b1;
            n_rsp++;
            exp_q.push_back('{idx: h.mdata[IDX_W-1:0], data: line_data(h.address)});
        end
    endtask

    task automatic clear_logs();
        pend_q.delete();
        exp_q.delete();
        req_log.delete();
        n_req = 0; n_rsp = 0; n_out = 0; done_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (c0_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", c0_tx_valid); end
        n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (c0_tx_hdr !== '0)     begin n_fail++; $display("FAIL rst_tx_hdr: got %h want 0", c0_tx_hdr); end
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1, 0);
    endtask

    task automatic test_basic();
        exp_t e;
        int   t0, bad;
        clear_logs();
        tick(1'b1, 0);
        t0 = cyc; base_addr = 42'h1000; num_lines = 4; start = 1'b1;
        tick(1'b1, 1);
        n_checks++; if (got_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_T1: got %b want 1", got_busy); end
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            tick(1'b1, 1);
            if (popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL basic_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
        end
        repeat (3) tick(1'b1, 1);
        n_checks++; if (n_req != 4)    begin n_fail++; $display("FAIL basic_req_count: got %0d want 4", n_req); end
        n_checks++; if (req_log.size() == 0 || req_log[0].cyc != t0 + 2) begin n_fail++; $display("FAIL basic_first_req_T2: req_log size %0d want first req at cycle %0d", req_log.size(), t0 + 2); end
        bad = 0;
        foreach (req_log[k]) begin
            if (req_log[k].hdr !== exp_hdr(42'h1000 + t_ccip_clAddr'(k), k)) bad++;
            if (k > 0 && req_log[k].cyc != req_log[k-1].cyc + 1) bad++;
        end
        n_checks++; if (bad != 0)      begin n_fail++; $display("FAIL basic_req_hdrs: %0d bad headers/gaps, want 0", bad); end
        n_checks++; if (n_out != 4)    begin n_fail++; $display("FAIL basic_out_count: got %0d want 4", n_out); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_credit();
        exp_t e;
        int   bad;
        clear_logs();
        tick(1'b0, 0);
        base_addr = 42'h4000; num_lines = 40; start = 1'b1;
        repeat (80) tick(1'b0, 1);
        n_checks++; if (n_req != FIFO_DEPTH) begin n_fail++; $display("FAIL credit_stall_reqs: got %0d want %0d", n_req, FIFO_DEPTH); end
        n_checks++; if (got_vld !== 1'b1 || got_idx !== 16'd0 || got_data !== line_data(42'h4000)) begin
            n_fail++; $display("FAIL credit_hold_head: valid %b idx %0d data %h, want 1 0 %h", got_vld, got_idx, got_data[31:0], line_data(42'h4000) & 512'hFFFF_FFFF);
        end
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            tick(1'b1, 1);
            if (popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL credit_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL credit_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL credit_done: got %0d pulses want 1", done_cnt); end
        bad = 0;
        foreach (req_log[k]) if (req_log[k].hdr !== exp_hdr(42'h4000 + t_ccip_clAddr'(k), k)) bad++;
        n_checks++; if (n_req != 40 || bad != 0) begin n_fail++; $display("FAIL credit_reqs: got %0d reqs %0d bad, want 40 0", n_req, bad); end
        n_checks++; if (n_out != 40)   begin n_fail++; $display("FAIL credit_out_count: got %0d want 40", n_out); end
    endtask

    task automatic test_reverse();
        exp_t             e;
        logic [IDX_W-1:0] order[$];
        int               bad;
        t_ccip_clAddr     base;
        clear_logs();
        base = 42'h3FF_FFFF_FFFE;
        tick(1'b1, 0);
        base_addr = base; num_lines = 4; start = 1'b1;
        for (int i = 0; i < 20 && pend_q.size() < 4; i++) tick(1'b1, 0);
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            tick(1'b1, (i < 4) ? 2 : 0);
            if (popped) begin
                order.push_back(got_idx);
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rev_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL rev_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
        end
        bad = 0;
        foreach (order[k]) if (order[k] !== IDX_W'(3 - k)) bad++;
        n_checks++; if (order.size() != 4 || bad != 0) begin n_fail++; $display("FAIL rev_order: %0d outputs %0d out of order, want 4 0", order.size(), bad); end
        bad = 0;
        foreach (req_log[k]) if (req_log[k].hdr.address !== t_ccip_clAddr'(base + t_ccip_clAddr'(k))) bad++;
        n_checks++; if (n_req != 4 || bad != 0) begin n_fail++; $display("FAIL rev_addr_wrap: %0d reqs %0d bad addrs, want 4 0", n_req, bad); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rev_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_almfull();
        exp_t e;
        int   c_af, viol;
        clear_logs();
        c_af = 0; viol = 0;
        tick(1'b1, 0);
        base_addr = 42'h8000; num_lines = 20; start = 1'b1;
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            tick(1'b1, 1);
            if (popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL af_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL af_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
            if (c_af > 0 && got_req && cyc >= c_af + 1 && cyc <= c_af + 5) viol++;
            if (c_af == 0 && n_req >= 5) begin
                c0TxAlmFull = 1'b1; c_af = cyc;
            end else if (c_af > 0 && cyc == c_af + 5) begin
                c0TxAlmFull = 1'b0;
            end
        end
        c0TxAlmFull = 1'b0;
        n_checks++; if (c_af == 0 || viol != 0) begin n_fail++; $display("FAIL af_blocked: pulse at %0d, %0d reqs during block, want 0", c_af, viol); end
        n_checks++; if (n_req != 20)   begin n_fail++; $display("FAIL af_req_count: got %0d want 20", n_req); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL af_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_and_restart();
        exp_t e;
        int   bad;
        clear_logs();
        tick(1'b1, 0);
        base_addr = 42'h5000; num_lines = 0; start = 1'b1;
        tick(1'b1, 0);
        n_checks++; if (got_done !== 1'b1 || got_busy !== 1'b0) begin n_fail++; $display("FAIL zero_done_T1: done %b busy %b want 1 0", got_done, got_busy); end
        repeat (5) tick(1'b1, 0);
        n_checks++; if (n_req != 0 || done_cnt != 1) begin n_fail++; $display("FAIL zero_quiet: reqs %0d dones %0d want 0 1", n_req, done_cnt); end
        clear_logs();
        tick(1'b1, 0);
        base_addr = 42'hA000; num_lines = 4; start = 1'b1;
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            tick(1'b1, (i < 3) ? 0 : 1);
            if (i == 2) begin base_addr = 42'hB000; num_lines = 7; start = 1'b1; end
            if (popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL restart_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL restart_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
        end
        repeat (4) tick(1'b1, 1);
        bad = 0;
        foreach (req_log[k]) if (req_log[k].hdr !== exp_hdr(42'hA000 + t_ccip_clAddr'(k), k)) bad++;
        n_checks++; if (n_req != 4 || bad != 0) begin n_fail++; $display("FAIL restart_reqs: %0d reqs %0d bad, want 4 0", n_req, bad); end
        n_checks++; if (n_out != 4 || done_cnt != 1) begin n_fail++; $display("FAIL restart_done: outs %0d dones %0d want 4 1", n_out, done_cnt); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   stale;
        clear_logs();
        tick(1'b0, 0);
        base_addr = 42'hC000; num_lines = 8; start = 1'b1;
        for (int i = 0; i < 40 && n_rsp < 2; i++) tick(1'b0, (n_req >= 8) ? 1 : 0);
        tick(1'b0, 0);
        tick(1'b0, 0);
        n_checks++; if (got_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", got_vld); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0) begin n_fail++; $display("FAIL rstmid_out: valid %b idx %0d data %h want 0 0 0", out_valid, out_idx, out_data[31:0]); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_status: busy %b done %b want 0 0", busy, done); end
        n_checks++; if (c0_tx_valid !== 1'b0 || c0_tx_hdr !== '0) begin n_fail++; $display("FAIL rstmid_tx: valid %b hdr %h want 0 0", c0_tx_valid, c0_tx_hdr); end
        tick(1'b0, 0);
        tick(1'b0, 0);
        reset_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1);
            if (got_vld !== 1'b0 || got_done !== 1'b0) stale++;
        end
        tick(1'b1, 0);
        if (got_vld !== 1'b0) stale++;
        n_checks++; if (stale != 0 || done_cnt != 0) begin n_fail++; $display("FAIL rstmid_stale: %0d bad cycles %0d dones, want 0 0", stale, done_cnt); end
        clear_logs();
        base_addr = 42'hD000; num_lines = 2; start = 1'b1;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            tick(1'b1, 1);
            if (popped) begin
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_out_extra: idx %0d with nothing expected", got_idx); end
                else begin
                    e = exp_q.pop_front();
                    if (got_idx !== e.idx || got_data !== e.data) begin
                        n_fail++; $display("FAIL rstmid_new_out: idx %0d data %h, want idx %0d data %h", got_idx, got_data[31:0], e.idx, e.data[31:0]);
                    end
                end
            end
        end
        n_checks++; if (n_req != 2 || n_out != 2 || done_cnt != 1) begin n_fail++; $display("FAIL rstmid_new_xfer: reqs %0d outs %0d dones %0d want 2 2 1", n_req, n_out, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_reverse();
        test_almfull();
        test_zero_and_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
